// File: rtl/vga_timing_pkg.sv
// Timing constants, sync bundle type and raw sync decode for the 640x480@60Hz generator.
package vga_timing_pkg;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t H_VISIBLE = 10'd640;
  localparam cnt_t H_FP      = 10'd16;
  localparam cnt_t H_SYNC    = 10'd96;
  localparam cnt_t H_BP      = 10'd48;
  localparam cnt_t H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam cnt_t V_VISIBLE = 10'd480;
  localparam cnt_t V_FP      = 10'd10;
  localparam cnt_t V_SYNC    = 10'd2;
  localparam cnt_t V_BP      = 10'd33;
  localparam cnt_t V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_SYNC_START = H_VISIBLE + H_FP;
  localparam cnt_t H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam cnt_t V_SYNC_START = V_VISIBLE + V_FP;
  localparam cnt_t V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam cnt_t H_LAST       = H_TOTAL - 10'd1;
  localparam cnt_t V_LAST       = V_TOTAL - 10'd1;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank_n;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

  function automatic sync_t decode_sync(input cnt_t h, input cnt_t v);
    sync_t s;
    s.hs      = !((h >= H_SYNC_START) && (h < H_SYNC_END));
    s.vs      = !((v >= V_SYNC_START) && (v < V_SYNC_END));
    s.blank_n = (h < H_VISIBLE) && (v < V_VISIBLE);
    return s;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the VGA timing generator: colour in, coordinates/strobes and DAC pins out.
// frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
  logic [7:0] r_in;
  logic [7:0] g_in;
  logic [7:0] b_in;
  logic [9:0] draw_x;
  logic [9:0] draw_y;
  logic       pix_en;
  logic       frame_start;
  logic       vga_clk;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_blank_n;
  logic       vga_sync_n;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  modport master (
    input  r_in, g_in, b_in,
    output draw_x, draw_y, pix_en, frame_start, vga_clk, vga_hs, vga_vs,
           vga_blank_n, vga_sync_n, vga_r, vga_g, vga_b
`ifdef VGA_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    output r_in, g_in, b_in,
    input  draw_x, draw_y, pix_en, frame_start, vga_clk, vga_hs, vga_vs,
           vga_blank_n, vga_sync_n, vga_r, vga_g, vga_b
`ifdef VGA_FRAME_CNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/vga_sync_delay.sv
// Shift register aligning {hs,vs,blank_n} with the colour pipeline; resets to the idle bundle.
// DEPTH=0 still registers once; the caller then enables it every clock.
module vga_sync_delay
  import vga_timing_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  en_i,
  input  sync_t d_i,
  output sync_t q_o,
  output sync_t q_next_o
);

  localparam int unsigned STAGES = (DEPTH == 0) ? 1 : DEPTH;

  sync_t stage_q [STAGES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= SYNC_IDLE;
    end else if (en_i) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  // q_next_o is what the output stage loads on the next enable, so the colour
  // register can blank on the same strobe that blank_n changes.
  generate
    if (STAGES == 1) begin : g_one
      assign q_next_o = d_i;
    end else begin : g_multi
      assign q_next_o = stage_q[STAGES-2];
    end
  endgenerate

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60Hz timing from the 50 MHz clock: pixel strobe, counters, delayed sync/blank, colour register.
// Optional frame counter port built when VGA_FRAME_CNT_EN is defined.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned PIPE_DLY = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  vga_timing_gen_if.master vga
);

  logic        pix_div_q;
  cnt_t        h_cnt_q, h_cnt_d;
  cnt_t        v_cnt_q, v_cnt_d;
  logic        h_wrap, v_wrap;
  logic        frame_start_q, frame_start_d;
  logic [23:0] rgb_q, rgb_d;
  logic        dly_en;
  sync_t       sync_raw, sync_q, sync_next;

  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    h_wrap        = (h_cnt_q >= H_LAST);
    v_wrap        = (v_cnt_q >= V_LAST);
    frame_start_d = pix_div_q && h_wrap && v_wrap;
    if (pix_div_q) begin
      if (h_wrap) begin
        h_cnt_d = '0;
        v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pix_div_q     <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      pix_div_q     <= ~pix_div_q;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_start_q <= frame_start_d;
    end
  end

  // With no pixel lag requested the sync register simply follows every clock.
  assign dly_en   = (PIPE_DLY == 0) ? 1'b1 : pix_div_q;
  assign sync_raw = decode_sync(h_cnt_q, v_cnt_q);

  vga_sync_delay #(.DEPTH(PIPE_DLY)) u_sync_delay (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (dly_en),
    .d_i      (sync_raw),
    .q_o      (sync_q),
    .q_next_o (sync_next)
  );

  always_comb begin
    rgb_d = rgb_q;
    if (dly_en) rgb_d = sync_next.blank_n ? {vga.r_in, vga.g_in, vga.b_in} : 24'h0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rgb_q <= '0;
    else       rgb_q <= rgb_d;
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  assign frame_cnt_d = frame_cnt_q + {15'd0, frame_start_q};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end

  assign vga.frame_cnt = frame_cnt_q;
`endif

  assign vga.draw_x      = h_cnt_q;
  assign vga.draw_y      = v_cnt_q;
  assign vga.pix_en      = pix_div_q;
  assign vga.vga_clk     = pix_div_q;
  assign vga.frame_start = frame_start_q;
  assign vga.vga_hs      = sync_q.hs;
  assign vga.vga_vs      = sync_q.vs;
  assign vga.vga_blank_n = sync_q.blank_n;
  assign vga.vga_sync_n  = 1'b0;
  assign vga.vga_r       = rgb_q[23:16];
  assign vga.vga_g       = rgb_q[15:8];
  assign vga.vga_b       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: reset, line/frame sync placement, blanking, mid-frame reset.
// Vertical position is preloaded by forcing the line counter so frame events stay within a short run.
module tb_vga_timing_gen;

  logic clk_i;
  logic rst_i;
  int   n_tests;
  int   n_fail;
  int   exp_frames;

  vga_timing_gen_if vif ();

  vga_timing_gen #(.PIPE_DLY(1)) u_dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .vga   (vif)
  );

  initial clk_i = 1'b0;
  always #10 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_x(input logic [9:0] x);
    int k;
    k = 0;
    while (vif.draw_x != x && k < 2000) begin
      @(negedge clk_i);
      k++;
    end
    if (k >= 2000) check_val("wait_x_timeout", 0, 1);
  endtask

  task automatic preload_line(input logic [9:0] y);
    wait_x(10'd10);
    force u_dut.v_cnt_q = y;
    @(negedge clk_i);
    @(negedge clk_i);
    release u_dut.v_cnt_q;
  endtask

  // Jumps to the last lines of the frame and checks the wrap pulse.
  task automatic run_frame();
    int k;
    preload_line(10'd523);
    k = 0;
    while (vif.frame_start !== 1'b1 && k < 5000) begin
      @(negedge clk_i);
      k++;
    end
    check_val("fs_seen", {31'd0, vif.frame_start}, 1);
    check_val("fs_x", {22'd0, vif.draw_x}, 0);
    check_val("fs_y", {22'd0, vif.draw_y}, 0);
    exp_frames++;
    @(negedge clk_i);
    check_val("fs_width", {31'd0, vif.frame_start}, 0);
`ifdef VGA_FRAME_CNT_EN
    check_val("frame_cnt", {16'd0, vif.frame_cnt}, exp_frames);
`endif
  endtask

  initial begin
    int   k;
    logic prev_hs, prev_vs, prev_blank, in_low, done_hs;
    logic [9:0] prev_x;
    int   low_px, wraps, wrap_t0, low_clk, fs_cnt;

    n_tests    = 0;
    n_fail     = 0;
    exp_frames = 0;
    rst_i      = 1'b1;
    vif.r_in   = 8'hFF;
    vif.g_in   = 8'h00;
    vif.b_in   = 8'h80;

    // Reset state
    repeat (3) @(negedge clk_i);
    check_val("rst_hs", {31'd0, vif.vga_hs}, 1);
    check_val("rst_vs", {31'd0, vif.vga_vs}, 1);
    check_val("rst_blank", {31'd0, vif.vga_blank_n}, 0);
    check_val("rst_rgb", {8'd0, vif.vga_r, vif.vga_g, vif.vga_b}, 0);
    check_val("rst_x", {22'd0, vif.draw_x}, 0);
    check_val("rst_pix_en", {31'd0, vif.pix_en}, 0);
    check_val("rst_fs", {31'd0, vif.frame_start}, 0);
    check_val("sync_n", {31'd0, vif.vga_sync_n}, 0);

    // Release: strobe 1 Clk later, DrawX steps every 2 Clk
    rst_i = 1'b0;
    @(negedge clk_i);
    check_val("rel_pix_en0", {31'd0, vif.pix_en}, 1);
    check_val("rel_x0", {22'd0, vif.draw_x}, 0);
    @(negedge clk_i);
    check_val("rel_pix_en1", {31'd0, vif.pix_en}, 0);
    check_val("rel_x1", {22'd0, vif.draw_x}, 1);
    check_val("rel_blank", {31'd0, vif.vga_blank_n}, 1);
    check_val("rel_rgb", {8'd0, vif.vga_r, vif.vga_g, vif.vga_b}, 32'hFF0080);
    @(negedge clk_i);
    check_val("rel_pix_en2", {31'd0, vif.pix_en}, 1);
    check_val("rel_x2", {22'd0, vif.draw_x}, 1);
    @(negedge clk_i);
    check_val("rel_x3", {22'd0, vif.draw_x}, 2);
    check_val("vga_clk", {31'd0, vif.vga_clk}, {31'd0, vif.pix_en});

    // Line: HS placement/width, line period, blanking vs colour
    prev_hs = vif.vga_hs; prev_blank = vif.vga_blank_n; prev_x = vif.draw_x;
    in_low = 0; done_hs = 0; low_px = 0; wraps = 0; wrap_t0 = 0;
    k = 0;
    while (!(done_hs && wraps >= 2) && k < 4000) begin
      @(negedge clk_i);
      k++;
      check_val("rgb_vs_blank", {8'd0, vif.vga_r, vif.vga_g, vif.vga_b},
                vif.vga_blank_n ? 32'hFF0080 : 32'h0);
      if (prev_hs && !vif.vga_hs) begin
        check_val("hs_fall_x", {22'd0, vif.draw_x}, 657);
        in_low = 1; low_px = 0;
      end
      if (in_low && !vif.vga_hs && vif.pix_en) low_px++;
      if (in_low && !prev_hs && vif.vga_hs) begin
        check_val("hs_low_px", low_px, 96);
        in_low = 0; done_hs = 1;
      end
      if (prev_blank && !vif.vga_blank_n) check_val("blank_fall_x", {22'd0, vif.draw_x}, 641);
      if (prev_x == 10'd799 && vif.draw_x == 10'd0) begin
        wraps++;
        if (wraps == 1) wrap_t0 = k;
        else if (wraps == 2) check_val("line_period", k - wrap_t0, 1600);
      end
      prev_hs = vif.vga_hs; prev_blank = vif.vga_blank_n; prev_x = vif.draw_x;
    end
    if (k >= 4000) check_val("line_timeout", 0, 1);

    // VS: falls one pixel after DrawY reaches 490, low for two lines
    preload_line(10'd489);
    prev_vs = vif.vga_vs;
    k = 0;
    while (!(prev_vs && !vif.vga_vs) && k < 5000) begin
      prev_vs = vif.vga_vs;
      @(negedge clk_i);
      k++;
    end
    check_val("vs_fall", {31'd0, vif.vga_vs}, 0);
    check_val("vs_fall_y", {22'd0, vif.draw_y}, 490);
    check_val("vs_fall_x", {22'd0, vif.draw_x}, 1);
    low_clk = 0;
    k = 0;
    while (!vif.vga_vs && k < 5000) begin
      low_clk++;
      @(negedge clk_i);
      k++;
    end
    check_val("vs_low_clk", low_clk, 3200);

    // Frame wrap pulses and frame counter
    repeat (3) run_frame();
`ifdef VGA_FRAME_CNT_EN
    force u_dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk_i);
    @(negedge clk_i);
    release u_dut.frame_cnt_q;
    exp_frames = 16'hFFFF;
    run_frame();
    check_val("frame_cnt_wrap", {16'd0, vif.frame_cnt}, 0);
`endif
    $display("[TB] frames seen %0d", exp_frames);

    // Mid-frame reset at (300,200)
    preload_line(10'd199);
    k = 0;
    while (!(vif.draw_y == 10'd200 && vif.draw_x == 10'd300) && k < 4000) begin
      @(negedge clk_i);
      k++;
    end
    check_val("pre_rst_y", {22'd0, vif.draw_y}, 200);
    check_val("pre_rst_blank", {31'd0, vif.vga_blank_n}, 1);
    rst_i = 1'b1;
    #1;
    check_val("mid_rst_x", {22'd0, vif.draw_x}, 0);
    check_val("mid_rst_y", {22'd0, vif.draw_y}, 0);
    check_val("mid_rst_blank", {31'd0, vif.vga_blank_n}, 0);
    check_val("mid_rst_hs_vs", {30'd0, vif.vga_hs, vif.vga_vs}, 3);
    check_val("mid_rst_rgb", {8'd0, vif.vga_r, vif.vga_g, vif.vga_b}, 0);
    check_val("mid_rst_pix_en", {31'd0, vif.pix_en}, 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    fs_cnt = 0;
    @(negedge clk_i);
    if (vif.frame_start) fs_cnt++;
    check_val("restart_pix_en", {31'd0, vif.pix_en}, 1);
    check_val("restart_x0", {22'd0, vif.draw_x}, 0);
    @(negedge clk_i);
    if (vif.frame_start) fs_cnt++;
    check_val("restart_x1", {22'd0, vif.draw_x}, 1);
    check_val("restart_y", {22'd0, vif.draw_y}, 0);
    repeat (40) begin
      @(negedge clk_i);
      if (vif.frame_start) fs_cnt++;
    end
    check_val("restart_no_fs", fs_cnt, 0);
    check_val("restart_x_run", {22'd0, vif.draw_x}, 21);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
